mem_access_ctrl: RTL and testbench

Multi-cycle sequencer for data-memory accesses in the LC-3b MEM stage. On a start request it decodes the opcode, drives the data-memory port, and waits on the memory response. It performs both steps of indirect loads and stores (LDI/STI) and aligns byte data for LDB/STB. While an access is in flight it stalls the pipeline, and it pulses `done` with the load result.

---
 rtl/mem_access_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: LC-3b MEM-stage data-memory sequencer.
// Runs the single access of LDR/STR/LDB/STB and both accesses of LDI/STI
// (pointer fetch, then data access). It holds the pipeline while an access
// is outstanding and pulses done with the registered load result.

package lc3b_types;
    typedef logic [15:0] lc3b_word;
    typedef logic [3:0]  lc3b_opcode;

    // Only the memory opcodes matter to this block.
    localparam lc3b_opcode op_ldb = 4'b0010;
    localparam lc3b_opcode op_stb = 4'b0011;
    localparam lc3b_opcode op_ldr = 4'b0110;
    localparam lc3b_opcode op_str = 4'b0111;
    localparam lc3b_opcode op_ldi = 4'b1010;
    localparam lc3b_opcode op_sti = 4'b1011;
endpackage

module mem_access_ctrl
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  opcode,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        mem_resp,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_byte_enable,
    output logic [15:0] rdata,
    output logic        done,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        IND  = 2'b01,
        ACC  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t     state, state_nxt;

    lc3b_opcode op_q;
    lc3b_word   addr_q;
    lc3b_word   wdata_q;
    lc3b_word   ptr_q;
    lc3b_word   rdata_q;

    function automatic logic is_mem_op(input lc3b_opcode op);
        return (op == op_ldr) || (op == op_str) || (op == op_ldb) ||
               (op == op_stb) || (op == op_ldi) || (op == op_sti);
    endfunction

    function automatic logic is_ind_op(input lc3b_opcode op);
        return (op == op_ldi) || (op == op_sti);
    endfunction

    function automatic logic is_store_op(input lc3b_opcode op);
        return (op == op_str) || (op == op_stb) || (op == op_sti);
    endfunction

    // A start is only taken in IDLE and only for a memory opcode; anything
    // else leaves the pipeline running untouched.
    logic accept;
    assign accept = (state == IDLE) && start && is_mem_op(opcode);

    // Data-phase address: indirect ops use the fetched pointer. Byte ops
    // keep the raw address since bit0 selects the lane; word ops are aligned.
    logic     byte_op;
    lc3b_word eff_addr;
    lc3b_word acc_addr;

    assign byte_op  = (op_q == op_ldb) || (op_q == op_stb);
    assign eff_addr = is_ind_op(op_q) ? ptr_q : addr_q;
    assign acc_addr = byte_op ? eff_addr : {eff_addr[15:1], 1'b0};

    // LDB picks its byte out of the full-word read; stores return 0.
    logic [7:0] load_byte;
    lc3b_word   load_result;

    assign load_byte = eff_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0];

    always_comb begin
        load_result = mem_rdata;
        if (is_store_op(op_q)) begin
            load_result = '0;
        end else if (op_q == op_ldb) begin
            load_result = {{8{load_byte[7]}}, load_byte};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; mem_resp only advances IND and ACC.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = is_ind_op(opcode) ? IND : ACC;
                end
            end
            IND: begin
                if (mem_resp) begin
                    state_nxt = ACC;
                end
            end
            ACC: begin
                if (mem_resp) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the request at acceptance so later input changes are invisible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            op_q    <= opcode;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Pointer fetched by the first half of LDI/STI.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if ((state == IND) && mem_resp) begin
            ptr_q <= mem_rdata;
        end
    end

    // Load result captured on the completing data access, shown during DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if ((state == ACC) && mem_resp) begin
            rdata_q <= load_result;
        end
    end

    // Memory port decode: a function of state and latched request only, so
    // strobes hold steady across wait cycles and vanish with an async reset.
    always_comb begin
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b00;
        mem_address     = '0;
        mem_wdata       = '0;
        case (state)
            IND: begin
                mem_read        = 1'b1;
                mem_byte_enable = 2'b11;
                mem_address     = {addr_q[15:1], 1'b0};
            end
            ACC: begin
                mem_address = acc_addr;
                if (is_store_op(op_q)) begin
                    mem_write = 1'b1;
                    if (op_q == op_stb) begin
                        mem_wdata       = {wdata_q[7:0], wdata_q[7:0]};
                        mem_byte_enable = eff_addr[0] ? 2'b10 : 2'b01;
                    end else begin
                        mem_wdata       = wdata_q;
                        mem_byte_enable = 2'b11;
                    end
                end else begin
                    mem_read        = 1'b1;
                    mem_byte_enable = 2'b11;
                end
            end
            default: begin
                mem_read        = 1'b0;
                mem_write       = 1'b0;
            end
        endcase
    end

    // Stall from the accepting cycle until the data access completes.
    assign stall = accept || (state == IND) || (state == ACC);
    assign done  = (state == DONE);
    assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: the bench plays the memory, answering strobes
// after a chosen number of wait cycles, and compares every transaction with
// expected values from a fixed vector table or from a rule-level model.
module tb_mem_access_ctrl;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_STB = 4'b0011;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  opcode = '0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        mem_resp = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] rdata;
    logic        done;
    logic        stall;

    int n_chk = 0;
    int n_fail = 0;

    mem_access_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .opcode          (opcode),
        .addr            (addr),
        .wdata           (wdata),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .rdata           (rdata),
        .done            (done),
        .stall           (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] w;
        logic [15:0] d_ind;
        logic [15:0] d_acc;
        int          wi;
        int          wa;
        bit          chk_addr;
        logic [15:0] x_addr;
        logic [1:0]  x_be;
        logic [15:0] x_wdata;
        logic [15:0] x_rdata;
        int          x_lat;
    } vec_t;

    // Snapshot layout: {read, write, be[1:0], address[15:0], wdata[15:0]}
    typedef struct {
        logic [35:0] snap0;
        logic [35:0] snap1;
        int          nph;
        logic [15:0] rdata;
        int          lat;
    } obs_t;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_ind(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

    function automatic bit is_st(input logic [3:0] op);
        return (op == OP_STR) || (op == OP_STB) || (op == OP_STI);
    endfunction

    // Expected outcome of one access, straight from the access rules.
    function automatic vec_t model(input logic [3:0] op, input logic [15:0] a, w, di, da,
                                   input int wi, wa);
        vec_t v;
        logic [15:0] eff;
        logic [7:0]  b;
        v.op = op; v.a = a; v.w = w; v.d_ind = di; v.d_acc = da; v.wi = wi; v.wa = wa;
        eff = is_ind(op) ? di : a;
        v.chk_addr = (op != OP_LDB);
        v.x_addr = (op == OP_STB) ? eff : (eff & 16'hFFFE);
        v.x_be = (op == OP_STB) ? (eff[0] ? 2'b10 : 2'b01) : 2'b11;
        v.x_wdata = (op == OP_STB) ? {w[7:0], w[7:0]} : w;
        b = eff[0] ? da[15:8] : da[7:0];
        if (is_st(op)) v.x_rdata = 16'h0000;
        else if (op == OP_LDB) v.x_rdata = {{8{b[7]}}, b};
        else v.x_rdata = da;
        v.x_lat = (is_ind(op) ? wi + 1 : 0) + wa + 2;
        return v;
    endfunction

    // Issue one request and act as memory until done; returns the observed
    // access snapshots, load result and start-to-done latency.
    task automatic do_txn(input vec_t v, output obs_t o);
        bit stall_ok = 1'b1;
        bit stable_ok = 1'b1;
        bit proto_ok = 1'b1;
        bit timeout = 1'b1;
        int ph = 0;
        int pc = 0;
        int wt;
        logic [35:0] cur;
        o.snap0 = '0; o.snap1 = '0; o.nph = 0; o.rdata = '0; o.lat = 0;
        @(posedge clk); #1;
        start = 1'b1; opcode = v.op; addr = v.a; wdata = v.w; mem_resp = 1'b0;
        @(negedge clk);
        chk("stall_on_accept", 36'(stall), 36'(1));
        @(posedge clk); #1;
        start = 1'b0; opcode = 4'($urandom); addr = 16'($urandom); wdata = 16'($urandom);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            mem_resp = 1'b0;
            mem_rdata = 16'($urandom);
            if (done) begin
                o.lat = cyc;
                o.rdata = rdata;
                timeout = 1'b0;
                break;
            end
            if (!stall) stall_ok = 1'b0;
            cur = {mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata};
            if (!(mem_read || mem_write) || ph > 1) begin
                proto_ok = 1'b0;
            end else begin
                if (pc == 0) begin
                    if (ph == 0) o.snap0 = cur; else o.snap1 = cur;
                end else if (cur !== ((ph == 0) ? o.snap0 : o.snap1)) begin
                    stable_ok = 1'b0;
                end
                wt = (is_ind(v.op) && ph == 0) ? v.wi : v.wa;
                if (pc == wt) begin
                    mem_resp = 1'b1;
                    mem_rdata = (is_ind(v.op) && ph == 0) ? v.d_ind : v.d_acc;
                    ph++;
                    pc = 0;
                end else begin
                    pc++;
                end
            end
            @(posedge clk); #1;
        end
        mem_resp = 1'b0;
        o.nph = ph;
        chk("done_timeout", 36'(timeout), 36'(0));
        chk("stall_in_done", 36'(stall), 36'(0));
        chk("stall_while_busy", 36'(stall_ok), 36'(1));
        chk("strobes_stable", 36'(stable_ok), 36'(1));
        chk("access_sequence", 36'(proto_ok && (ph == (is_ind(v.op) ? 2 : 1))), 36'(1));
    endtask

    task automatic check_vec(input string tag, input vec_t v, input obs_t o);
        logic [35:0] acc;
        acc = is_ind(v.op) ? o.snap1 : o.snap0;
        if (is_ind(v.op)) begin
            chk($sformatf("%s ind_port", tag), 36'(o.snap0[35:16]),
                36'({1'b1, 1'b0, 2'b11, v.a & 16'hFFFE}));
        end
        chk($sformatf("%s read", tag), 36'(acc[35]), 36'(!is_st(v.op)));
        chk($sformatf("%s write", tag), 36'(acc[34]), 36'(is_st(v.op)));
        chk($sformatf("%s byte_en", tag), 36'(acc[33:32]), 36'(v.x_be));
        if (v.chk_addr) chk($sformatf("%s address", tag), 36'(acc[31:16]), 36'(v.x_addr));
        if (is_st(v.op)) chk($sformatf("%s wdata", tag), 36'(acc[15:0]), 36'(v.x_wdata));
        chk($sformatf("%s rdata", tag), 36'(o.rdata), 36'(v.x_rdata));
        chk($sformatf("%s latency", tag), 36'(o.lat), 36'(v.x_lat));
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [15:0] a, w, di, da,
                                input int wi, wa, input bit ca, input logic [15:0] xa,
                                input logic [1:0] xbe, input logic [15:0] xw, xr, input int xl);
        vec_t v;
        v.op = op; v.a = a; v.w = w; v.d_ind = di; v.d_acc = da; v.wi = wi; v.wa = wa;
        v.chk_addr = ca; v.x_addr = xa; v.x_be = xbe; v.x_wdata = xw; v.x_rdata = xr;
        v.x_lat = xl;
        return v;
    endfunction

    initial begin
        vec_t tbl[10];
        vec_t v;
        obs_t o;
        logic [3:0] mem_ops[6];
        logic [3:0] other_ops[10];
        bit bad;

        mem_ops = '{OP_LDR, OP_STR, OP_LDB, OP_STB, OP_LDI, OP_STI};
        other_ops = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h8, 4'h9, 4'hC, 4'hD, 4'hE, 4'hF};

        //            op      addr      wdata     d_ind     d_acc    wi wa chkA x_addr   be     x_wdata   x_rdata  lat
        tbl[0] = mk(OP_LDR, 16'h3001, 16'h0000, 16'h0000, 16'hBEEF, 0, 0, 1, 16'h3000, 2'b11, 16'h0000, 16'hBEEF, 2);
        tbl[1] = mk(OP_STB, 16'h4001, 16'h12A5, 16'h0000, 16'h0000, 0, 0, 1, 16'h4001, 2'b10, 16'hA5A5, 16'h0000, 2);
        tbl[2] = mk(OP_STB, 16'h4000, 16'h12A5, 16'h0000, 16'h0000, 0, 0, 1, 16'h4000, 2'b01, 16'hA5A5, 16'h0000, 2);
        tbl[3] = mk(OP_LDB, 16'h5001, 16'h0000, 16'h0000, 16'h80FF, 0, 0, 0, 16'h0000, 2'b11, 16'h0000, 16'hFF80, 2);
        tbl[4] = mk(OP_LDB, 16'h5000, 16'h0000, 16'h0000, 16'h80FF, 0, 0, 0, 16'h0000, 2'b11, 16'h0000, 16'hFFFF, 2);
        tbl[5] = mk(OP_LDI, 16'h6000, 16'h0000, 16'h7002, 16'h1234, 0, 0, 1, 16'h7002, 2'b11, 16'h0000, 16'h1234, 3);
        tbl[6] = mk(OP_LDI, 16'h6000, 16'h0000, 16'h7002, 16'h1234, 2, 2, 1, 16'h7002, 2'b11, 16'h0000, 16'h1234, 7);
        tbl[7] = mk(OP_STR, 16'h2003, 16'hCAFE, 16'h0000, 16'h0000, 0, 0, 1, 16'h2002, 2'b11, 16'hCAFE, 16'h0000, 2);
        tbl[8] = mk(OP_STI, 16'h0011, 16'h5555, 16'h8001, 16'h0000, 0, 1, 1, 16'h8000, 2'b11, 16'h5555, 16'h0000, 4);
        tbl[9] = mk(OP_LDB, 16'h0FF1, 16'h0000, 16'h0000, 16'h7F80, 0, 3, 0, 16'h0000, 2'b11, 16'h0000, 16'h007F, 5);

        // Reset state: every output is zero while reset is held.
        #3;
        chk("reset_outputs", 36'({mem_read, mem_write, mem_byte_enable, done, stall,
                                  mem_address, mem_wdata, rdata}), 36'(0));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            do_txn(tbl[i], o);
            check_vec($sformatf("vec%0d", i), tbl[i], o);
        end

        // Non-memory opcode: no stall, no strobes, no done.
        @(posedge clk); #1;
        start = 1'b1; opcode = OP_ADD; addr = 16'h1234;
        @(negedge clk);
        chk("add_stall", 36'(stall), 36'(0));
        @(posedge clk); #1;
        start = 1'b0;
        chk("add_no_access", 36'({mem_read, mem_write, mem_byte_enable, done}), 36'(0));

        // start and mem_resp in DONE are ignored; the next cycle accepts.
        v = model(OP_LDR, 16'h0A0A, 16'h0, 16'h0, 16'h5A5A, 0, 1);
        do_txn(v, o);
        check_vec("pre_done", v, o);
        start = 1'b1; opcode = OP_LDR; addr = 16'h1235; mem_resp = 1'b1; mem_rdata = 16'hFFFF;
        @(negedge clk);
        chk("done_start_stall", 36'(stall), 36'(0));
        @(posedge clk); #1;
        mem_resp = 1'b0;
        chk("done_start_ignored", 36'({mem_read, mem_write, done}), 36'(0));
        @(negedge clk);
        chk("idle_accept_stall", 36'(stall), 36'(1));
        @(posedge clk); #1;
        start = 1'b0;
        chk("idle_accept_read", 36'({mem_read, mem_address}), 36'({1'b1, 16'h1234}));
        mem_resp = 1'b1; mem_rdata = 16'h4321;
        @(posedge clk); #1;
        mem_resp = 1'b0;
        chk("idle_accept_done", 36'({done, rdata}), 36'({1'b1, 16'h4321}));

        // Reset while an STI is in its data phase abandons the access.
        @(posedge clk); #1;
        start = 1'b1; opcode = OP_STI; addr = 16'h0100; wdata = 16'h9999;
        @(posedge clk); #1;
        start = 1'b0;
        mem_resp = 1'b1; mem_rdata = 16'h2000;
        @(posedge clk); #1;
        mem_resp = 1'b0;
        chk("sti_acc_write", 36'({mem_write, mem_address}), 36'({1'b1, 16'h2000}));
        #2 reset_n = 1'b0;
        #1;
        chk("sti_reset_drop", 36'({mem_read, mem_write, mem_byte_enable, stall, done, mem_address}), 36'(0));
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done || mem_read || mem_write || stall) bad = 1'b1;
        end
        chk("sti_reset_quiet", 36'(bad), 36'(0));
        v = model(OP_LDR, 16'h0C07, 16'h0, 16'h0, 16'h0BAD, 0, 0);
        do_txn(v, o);
        check_vec("post_reset", v, o);

        // Randomized traffic against the rule-level model.
        for (int n = 0; n < 40; n++) begin
            int idle;
            idle = int'($urandom_range(0, 2));
            for (int k = 0; k < idle; k++) begin
                @(posedge clk); #1;
                start = 1'b1; opcode = other_ops[$urandom_range(0, 9)];
                addr = 16'($urandom);
                @(negedge clk);
                chk("rand_nonmem_idle", 36'({stall, mem_read, mem_write}), 36'(0));
                start = 1'b0;
            end
            v = model(mem_ops[$urandom_range(0, 5)], 16'($urandom), 16'($urandom),
                      16'($urandom), 16'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            do_txn(v, o);
            check_vec($sformatf("rand%0d", n), v, o);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
